// File: rtl/sift_ori_hist_if.sv
// Sample stream into, and dominant-orientation result out of, the orientation histogram block.
interface sift_ori_hist_if #(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_dir;
  logic [MAG_W-1:0] in_mag;
  logic             out_valid;
  logic [4:0]       out_dir;
  logic [ACC_W-1:0] out_peak;

  modport master (
    output in_valid, in_dir, in_mag,
    input  in_ready, out_valid, out_dir, out_peak
  );

  modport slave (
    input  in_valid, in_dir, in_mag,
    output in_ready, out_valid, out_dir, out_peak
  );
endinterface

// File: rtl/sift_ori_hist.sv
// 32-bin saturating gradient orientation histogram for one keypoint window,
// followed by a 32-cycle arg-max scan reporting the dominant bin and its weight.
module sift_ori_hist #(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned WIN_N = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  sift_ori_hist_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SEARCH, DONE} state_t;

  localparam int unsigned      SUM_W    = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [16:0]      WIN_LAST = 17'(WIN_N);

  state_t           state_q;
  logic [ACC_W-1:0] bin_q [32];
  logic [15:0]      cnt_q;
  logic [4:0]       idx_q;
  logic [4:0]       arg_q;
  logic [ACC_W-1:0] max_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [4:0]       out_dir_q;
  logic [ACC_W-1:0] out_peak_q;
  logic             busy_q;

  logic             accept;
  logic             last_sample;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] max_d;
  logic [4:0]       arg_d;

  always_comb begin
    accept      = (state_q == ACCUM) && in_ready_q && bus.in_valid;
    last_sample = ({1'b0, cnt_q} + 17'd1) == WIN_LAST;
    sum         = SUM_W'(bin_q[bus.in_dir]) + SUM_W'(bus.in_mag);
    acc_d       = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_W-1:0];
    max_d       = max_q;
    arg_d       = arg_q;
    if (bin_q[idx_q] > max_q) begin
      max_d = bin_q[idx_q];
      arg_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < 32; i++) bin_q[i] <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dir_q   <= '0;
      out_peak_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          for (int unsigned i = 0; i < 32; i++) bin_q[i] <= '0;
          cnt_q      <= '0;
          idx_q      <= '0;
          arg_q      <= '0;
          max_q      <= '0;
          in_ready_q <= 1'b1;
          state_q    <= ACCUM;
        end
        ACCUM: begin
          if (accept) begin
            bin_q[bus.in_dir] <= acc_d;
            cnt_q             <= cnt_q + 16'd1;
            if (last_sample) begin
              in_ready_q <= 1'b0;
              state_q    <= SEARCH;
            end
          end
        end
        SEARCH: begin
          max_q <= max_d;
          arg_q <= arg_d;
          idx_q <= idx_q + 5'd1;
          // Result is captured from the final compare so it is already valid during DONE.
          if (idx_q == 5'd31) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_dir_q   <= arg_d;
            out_peak_q  <= max_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dir   = out_dir_q;
  assign bus.out_peak  = out_peak_q;

endmodule

// File: tb/tb_sift_ori_hist.sv
// Randomised scoreboard bench: instance A (defaults) and instance B (ACC_W=8, WIN_N=4).
module tb_sift_ori_hist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, busy_b;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sift_ori_hist_if #(.MAG_W(8), .ACC_W(16)) a_if ();
  sift_ori_hist_if #(.MAG_W(8), .ACC_W(8))  b_if ();

  sift_ori_hist #(.MAG_W(8), .ACC_W(16), .WIN_N(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .bus(a_if.slave)
  );
  sift_ori_hist #(.MAG_W(8), .ACC_W(8), .WIN_N(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .bus(b_if.slave)
  );

  typedef struct {int dir; int peak;} exp_t;
  exp_t q_exp [2][$];
  int   last_acc [2];
  int   compared = 0;
  int   mismatched = 0;
  int   win_dir [$];
  int   win_mag [$];

  task automatic chk(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_in(input bit sel, input bit v, input int d, input int m);
    if (sel) begin
      b_if.in_valid = v; b_if.in_dir = 5'(d); b_if.in_mag = 8'(m);
    end else begin
      a_if.in_valid = v; a_if.in_dir = 5'(d); a_if.in_mag = 8'(m);
    end
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  function automatic bit get_ready(input bit sel);
    return sel ? b_if.in_ready : a_if.in_ready;
  endfunction

  function automatic bit get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic bit get_ovalid(input bit sel);
    return sel ? b_if.out_valid : a_if.out_valid;
  endfunction

  // Scoreboard monitors: one per instance, sampled on the falling edge.
  task automatic monitor_one(input bit sel);
    exp_t e;
    int   got_dir, got_peak;
    got_dir  = sel ? int'(b_if.out_dir)  : int'(a_if.out_dir);
    got_peak = sel ? int'(b_if.out_peak) : int'(a_if.out_peak);
    if (q_exp[sel].size() == 0) begin
      chk(sel ? "b_unexpected_out_valid" : "a_unexpected_out_valid", 1, 0);
    end else begin
      e = q_exp[sel].pop_front();
      chk(sel ? "b_out_dir" : "a_out_dir", got_dir, e.dir);
      chk(sel ? "b_out_peak" : "a_out_peak", got_peak, e.peak);
      // Visible in the cycle after edge last_acc+32, i.e. high at the 33rd edge.
      chk(sel ? "b_latency" : "a_latency", cyc - last_acc[sel], 32);
    end
  endtask

  always @(negedge clk) if (rst_n && a_if.out_valid) monitor_one(1'b0);
  always @(negedge clk) if (rst_n && b_if.out_valid) monitor_one(1'b1);

  // Drives win_dir/win_mag into one instance; the reference histogram is built
  // only from samples presented while in_ready was high.
  task automatic run_window(input bit sel, input int n, input bit full,
                            input int gap_pct, input bit poke);
    int hist [32];
    int acc = 0;
    int budget;
    int satmax;
    bit poked = 1'b0;
    bit v;
    exp_t e;
    satmax = sel ? 255 : 65535;
    foreach (hist[i]) hist[i] = 0;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    budget = n * 20 + 100;
    while (acc < n && budget > 0) begin
      @(negedge clk);
      budget--;
      set_start(sel, poke && !poked && acc == n / 2);
      if (poke && acc == n / 2) poked = 1'b1;
      v = ($urandom_range(99) >= gap_pct);
      set_in(sel, v, win_dir[acc], win_mag[acc]);
      if (v && get_ready(sel)) begin
        hist[win_dir[acc]] = (hist[win_dir[acc]] + win_mag[acc] > satmax) ?
                             satmax : hist[win_dir[acc]] + win_mag[acc];
        acc++;
        last_acc[sel] = cyc + 1;
      end
    end
    if (acc < n) chk(sel ? "b_accept_timeout" : "a_accept_timeout", acc, n);
    if (!full) return;
    @(negedge clk);
    set_start(sel, 1'b0);
    set_in(sel, 1'b1, 0, 255);
    chk(sel ? "b_ready_drop" : "a_ready_drop", get_ready(sel), 0);
    @(negedge clk);
    chk(sel ? "b_ready_held_low" : "a_ready_held_low", get_ready(sel), 0);
    set_in(sel, 1'b0, 0, 0);
    e.dir = 0; e.peak = 0;
    for (int d = 0; d < 32; d++)
      if (hist[d] > e.peak) begin e.peak = hist[d]; e.dir = d; end
    q_exp[sel].push_back(e);
  endtask

  task automatic wait_idle(input bit sel);
    int budget = 200;
    while (get_busy(sel) && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) chk(sel ? "b_idle_timeout" : "a_idle_timeout", get_busy(sel), 0);
  endtask

  task automatic poke_search_then_idle(input bit sel);
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    wait_idle(sel);
    @(negedge clk);
    chk(sel ? "b_start_in_search_ignored" : "a_start_in_search_ignored", get_busy(sel), 0);
  endtask

  task automatic poke_done(input bit sel);
    int budget = 100;
    while (!get_ovalid(sel) && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) chk(sel ? "b_done_timeout" : "a_done_timeout", 0, 1);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    chk(sel ? "b_start_at_done_ignored" : "a_start_at_done_ignored", get_busy(sel), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy_a"},      busy_a, 0);
    chk({tag, "_in_ready_a"},  a_if.in_ready, 0);
    chk({tag, "_out_valid_a"}, a_if.out_valid, 0);
    chk({tag, "_out_dir_a"},   a_if.out_dir, 0);
    chk({tag, "_out_peak_a"},  a_if.out_peak, 0);
    chk({tag, "_busy_b"},      busy_b, 0);
    chk({tag, "_out_peak_b"},  b_if.out_peak, 0);
  endtask

  task automatic fill(input int n, input int d, input int m);
    win_dir.delete(); win_mag.delete();
    for (int i = 0; i < n; i++) begin win_dir.push_back(d); win_mag.push_back(m); end
  endtask

  task automatic fill_two_shuffled(input int n, input int d0, input int d1, input int m);
    int k0 = n / 2, k1 = n - n / 2;
    win_dir.delete(); win_mag.delete();
    for (int i = 0; i < n; i++) begin
      if (k1 == 0 || (k0 > 0 && $urandom_range(1) == 0)) begin
        win_dir.push_back(d0); k0--;
      end else begin
        win_dir.push_back(d1); k1--;
      end
      win_mag.push_back(m);
    end
  endtask

  task automatic fill_random(input int n, input int max_dir, input int max_mag);
    win_dir.delete(); win_mag.delete();
    for (int i = 0; i < n; i++) begin
      win_dir.push_back($urandom_range(max_dir));
      win_mag.push_back($urandom_range(max_mag));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(1'b0, 1'b0, 0, 0);
    set_in(1'b1, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A: single bin, back-to-back
    fill(256, 5, 1);
    run_window(1'b0, 256, 1'b1, 0, 1'b0);
    wait_idle(1'b0);

    // A: two-way tie with gaps and a start pulse mid-window and during SEARCH
    fill_two_shuffled(256, 3, 7, 2);
    run_window(1'b0, 256, 1'b1, 30, 1'b1);
    poke_search_then_idle(1'b0);

    // A: all-zero magnitudes must give a fresh 0/0 result
    fill_random(256, 31, 0);
    run_window(1'b0, 256, 1'b1, 10, 1'b0);
    poke_done(1'b0);

    // A: random windows, concentrated and spread
    for (int w = 0; w < 3; w++) begin
      fill_random(256, (w == 0) ? 3 : 31, 255);
      run_window(1'b0, 256, 1'b1, 25, 1'b1);
      wait_idle(1'b0);
    end

    // A: reset mid-ACCUM after 100 samples, asserted mid-cycle
    fill_random(256, 31, 255);
    run_window(1'b0, 100, 1'b0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    set_in(1'b0, 1'b0, 0, 0);
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(256, 12, 3);
    run_window(1'b0, 256, 1'b1, 15, 1'b0);
    wait_idle(1'b0);

    // B: saturation and saturated tie (lower index wins)
    fill(4, 31, 200);
    run_window(1'b1, 4, 1'b1, 0, 1'b0);
    wait_idle(1'b1);
    fill_two_shuffled(4, 2, 9, 200);
    run_window(1'b1, 4, 1'b1, 20, 1'b0);
    poke_done(1'b1);
    for (int w = 0; w < 6; w++) begin
      fill_random(4, 3, 255);
      run_window(1'b1, 4, 1'b1, 30, 1'b1);
      wait_idle(1'b1);
    end

    repeat (40) @(negedge clk);
    chk("a_results_outstanding", q_exp[0].size(), 0);
    chk("b_results_outstanding", q_exp[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
